// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display feeder.
// Holds the FSM state encoding and the decimal-range helper.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WRITE,
      DONE
   } state_t;

   localparam int DIGITS_DEF = 8;
   localparam int BCD_W      = 4;

   function automatic longint max_dec(input int digits);
      longint r;
      r = 1;
      for (int i = 0; i < digits; i++) begin
         r = r * 10;
      end
      return r - 1;
   endfunction

   localparam longint MAX_DEC = max_dec(DIGITS_DEF);

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more.
// Purely combinational, one BCD nibble.
module bcd_add3_stage (
   input  logic [3:0] in,
   output logic [3:0] out
);

   assign out = (in >= 4'd5) ? in + 4'd3 : in;

endmodule

// File: rtl/bin2bcd_digit_writer.sv
// Sequential binary-to-BCD converter that streams its digits into the
// display digit store as one write strobe per digit, LSD first.
module bin2bcd_digit_writer
   import display_pkg::*;
#(
   parameter int BIN_W  = 27,
   parameter int DIGITS = DIGITS_DEF,
   parameter int SEL_W  = $clog2(DIGITS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic             write,
   output logic [3:0]       num,
   output logic [SEL_W-1:0] sel
);

   localparam int BCD_TOT = BCD_W * DIGITS;
   localparam int CNT_W   = $clog2(BIN_W);
   localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(max_dec(DIGITS));

   generate
      if (max_dec(DIGITS) >= (longint'(1) << BIN_W)) begin : g_range_chk
         $error("bin2bcd_digit_writer: 10^DIGITS-1 does not fit in BIN_W");
      end
   endgenerate

   state_t               state_q, state_d;
   logic [BIN_W-1:0]     bin_q, bin_d;
   logic [BCD_TOT-1:0]   bcd_q, bcd_d;
   logic [BCD_TOT-1:0]   bcd_adj;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SEL_W-1:0]     dig_q, dig_d;
   logic                 busy_d, done_d, ovf_d, write_d;
   logic [3:0]           num_d;
   logic [SEL_W-1:0]     sel_d;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_add3
         bcd_add3_stage u_add3 (
            .in  (bcd_q[g*BCD_W +: BCD_W]),
            .out (bcd_adj[g*BCD_W +: BCD_W])
         );
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      busy_d  = busy;
      done_d  = 1'b0;
      ovf_d   = overflow;
      write_d = 1'b0;
      num_d   = num;
      sel_d   = sel;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin_in;
               bcd_d   = '0;
               ovf_d   = (bin_in > MAX_VAL);
               cnt_d   = CNT_W'(BIN_W - 1);
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            if (cnt_q == '0) begin
               dig_d   = '0;
               state_d = WRITE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WRITE: begin
            write_d = 1'b1;
            sel_d   = dig_q;
            num_d   = overflow ? 4'hF : bcd_q[dig_q*BCD_W +: BCD_W];
            // Index saturates at the last digit; DONE follows.
            if (dig_q == SEL_W'(DIGITS - 1)) begin
               state_d = DONE;
            end else begin
               dig_d = dig_q + 1'b1;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         dig_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         write    <= 1'b0;
         num      <= 4'd0;
         sel      <= '0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         dig_q    <= dig_d;
         busy     <= busy_d;
         done     <= done_d;
         overflow <= ovf_d;
         write    <= write_d;
         num      <= num_d;
         sel      <= sel_d;
      end
   end

endmodule

// File: tb/tb_bin2bcd_digit_writer.sv
// Self-checking bench for bin2bcd_digit_writer against a decimal
// reference model built from integer division.
module tb_bin2bcd_digit_writer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [26:0] bin_in;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        write;
   logic [3:0]  num;
   logic [2:0]  sel;

   int checks;
   int errors;

   logic       rec_write [0:36];
   logic [2:0] rec_sel   [0:36];
   logic [3:0] rec_num   [0:36];
   logic       rec_done  [0:36];
   logic       rec_busy  [0:36];
   logic       rec_ov    [0:36];

   bin2bcd_digit_writer dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .write    (write),
      .num      (num),
      .sel      (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic record(input int c);
      rec_write[c] = write;
      rec_sel[c]   = sel;
      rec_num[c]   = num;
      rec_done[c]  = done;
      rec_busy[c]  = busy;
      rec_ov[c]    = overflow;
   endtask

   // Start one operation at E0 and capture outputs #1 after E0..E0+36.
   task automatic do_op(input logic [26:0] v, input int inj_c,
                        input int rst_c);
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      @(posedge clk);
      #1;
      start  = 1'b0;
      bin_in = 27'($urandom);
      record(0);
      for (int c = 1; c <= 36; c++) begin
         if (c == inj_c) begin
            start  = 1'b1;
            bin_in = 27'd42;
         end
         if (c == rst_c) reset = 1'b0;
         @(posedge clk);
         #1;
         start = 1'b0;
         reset = 1'b1;
         record(c);
      end
   endtask

   function automatic logic [3:0] ref_digit(input logic [26:0] v,
                                            input int k);
      longint q;
      if (v > 27'd99999999) return 4'hF;
      q = longint'(v);
      for (int i = 0; i < k; i++) q = q / 10;
      return 4'(q % 10);
   endfunction

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks += 6;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done got %b want 0", done);
      end
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf got %b want 0", overflow);
      end
      if (write !== 1'b0) begin
         errors++;
         $display("FAIL reset_write got %b want 0", write);
      end
      if (num !== 4'd0) begin
         errors++;
         $display("FAIL reset_num got %0h want 0", num);
      end
      if (sel !== 3'd0) begin
         errors++;
         $display("FAIL reset_sel got %0d want 0", sel);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_conversion(input logic [26:0] v);
      logic exp_ov;
      logic exp_w;
      exp_ov = (v > 27'd99999999);
      do_op(v, 0, 0);
      for (int c = 0; c <= 36; c++) begin
         exp_w = (c >= 28 && c <= 35);
         checks += 4;
         if (rec_write[c] !== exp_w) begin
            errors++;
            $display("FAIL conv_write v=%0d c=%0d got %b want %b",
                     v, c, rec_write[c], exp_w);
         end
         if (rec_done[c] !== (c == 36)) begin
            errors++;
            $display("FAIL conv_done v=%0d c=%0d got %b want %b",
                     v, c, rec_done[c], (c == 36));
         end
         if (rec_busy[c] !== (c <= 35)) begin
            errors++;
            $display("FAIL conv_busy v=%0d c=%0d got %b want %b",
                     v, c, rec_busy[c], (c <= 35));
         end
         if (rec_ov[c] !== exp_ov) begin
            errors++;
            $display("FAIL conv_ovf v=%0d c=%0d got %b want %b",
                     v, c, rec_ov[c], exp_ov);
         end
         if (exp_w) begin
            checks += 2;
            if (rec_sel[c] !== 3'(c - 28)) begin
               errors++;
               $display("FAIL conv_sel v=%0d c=%0d got %0d want %0d",
                        v, c, rec_sel[c], c - 28);
            end
            if (rec_num[c] !== ref_digit(v, c - 28)) begin
               errors++;
               $display("FAIL conv_num v=%0d c=%0d got %0h want %0h",
                        v, c, rec_num[c], ref_digit(v, c - 28));
            end
         end
      end
      checks += 2;
      if (rec_sel[36] !== 3'd7) begin
         errors++;
         $display("FAIL hold_sel v=%0d got %0d want 7", v, rec_sel[36]);
      end
      if (rec_num[36] !== ref_digit(v, 7)) begin
         errors++;
         $display("FAIL hold_num v=%0d got %0h want %0h",
                  v, rec_num[36], ref_digit(v, 7));
      end
   endtask

   task automatic test_overflow;
      test_conversion(27'd100000000);
      test_conversion(27'h7FFFFFF);
   endtask

   task automatic test_ignore_start;
      do_op(27'd12345678, 5, 0);
      for (int k = 0; k < 8; k++) begin
         checks += 2;
         if (rec_write[28 + k] !== 1'b1) begin
            errors++;
            $display("FAIL ign_write k=%0d got %b want 1",
                     k, rec_write[28 + k]);
         end
         if (rec_num[28 + k] !== ref_digit(27'd12345678, k)) begin
            errors++;
            $display("FAIL ign_num k=%0d got %0h want %0h", k,
                     rec_num[28 + k], ref_digit(27'd12345678, k));
         end
      end
      checks++;
      if (rec_done[36] !== 1'b1) begin
         errors++;
         $display("FAIL ign_done got %b want 1", rec_done[36]);
      end
      repeat (2) @(posedge clk);
      #1;
      checks += 2;
      if (write !== 1'b0) begin
         errors++;
         $display("FAIL ign_idle_write got %b want 0", write);
      end
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ign_idle_busy got %b want 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      do_op(27'd87654321, 0, 30);
      checks += 2;
      if (rec_write[28] !== 1'b1) begin
         errors++;
         $display("FAIL rmid_w28 got %b want 1", rec_write[28]);
      end
      if (rec_num[29] !== 4'd2) begin
         errors++;
         $display("FAIL rmid_n29 got %0h want 2", rec_num[29]);
      end
      for (int c = 30; c <= 36; c++) begin
         checks += 3;
         if (rec_write[c] !== 1'b0) begin
            errors++;
            $display("FAIL rmid_write c=%0d got %b want 0", c, rec_write[c]);
         end
         if (rec_done[c] !== 1'b0) begin
            errors++;
            $display("FAIL rmid_done c=%0d got %b want 0", c, rec_done[c]);
         end
         if (rec_busy[c] !== 1'b0) begin
            errors++;
            $display("FAIL rmid_busy c=%0d got %b want 0", c, rec_busy[c]);
         end
      end
      checks += 2;
      if (rec_sel[30] !== 3'd0) begin
         errors++;
         $display("FAIL rmid_sel got %0d want 0", rec_sel[30]);
      end
      if (rec_num[30] !== 4'd0) begin
         errors++;
         $display("FAIL rmid_num got %0h want 0", rec_num[30]);
      end
      test_conversion(27'd7);
   endtask

   task automatic test_back_to_back;
      logic [26:0] v;
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 3) == 0)
            v = 27'($urandom_range(100000000, 134217727));
         else
            v = 27'($urandom_range(0, 99999999));
         test_conversion(v);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      start  = 1'b0;
      bin_in = '0;
      test_reset;
      test_conversion(27'd12345678);
      test_conversion(27'd0);
      test_conversion(27'd99999999);
      test_overflow;
      test_ignore_start;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin2bcd_digit_writer.md
Name: bin2bcd_digit_writer

Overview:
Upstream feeder for the 8-digit seven-segment display store. On a start pulse it converts a binary value to packed BCD using a sequential double-dabble, one shift per clock. It then walks the digit store with DIGITS consecutive one-cycle write strobes, driving the store's write, num and sel inputs directly. This lets a counter or datapath show a decimal value without software-side digit splitting.

Parameters:
BIN_W, 27, width of binary input (2^27 > 99,999,999)
DIGITS, 8, number of BCD digits produced and written
SEL_W, 3, digit select width, equals $clog2(DIGITS)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request conversion; sampled only in IDLE
bin_in  input  BIN_W  binary value, captured on accepted start
busy  output  1  high in SHIFT and WRITE states
done  output  1  one-cycle pulse after the last digit write
overflow  output  1  registered; set when captured value > 10^DIGITS-1, held until next accepted start
write  output  1  digit-store write strobe
num  output  4  BCD digit value to store
sel  output  SEL_W  digit index; 0 = least significant, rightmost digit

Behaviour:
- One clock domain. Reset is synchronous and active-low (reset==0 sampled at a clk rising edge). All logic uses the single clk.
- Reset values: state=IDLE; busy=0; done=0; overflow=0; write=0; num=0; sel=0. The shift register and counters are cleared.
- Reset mid-operation: the operation aborts at that edge. write drops in the same cycle; no further strobes or done pulse occur.
- All outputs are registered; there are no combinational input-to-output paths.
- FSM states: IDLE, SHIFT, WRITE, DONE.
- IDLE: if start==1 at edge E0, then at E0:
  - capture bin_in;
  - clear the 4*DIGITS-bit BCD accumulator;
  - set overflow = (bin_in > 10^DIGITS-1), otherwise clear it;
  - bit counter = BIN_W-1;
  - go to SHIFT.
- start is ignored outside IDLE. It is level-sampled, so holding it high re-triggers on the first IDLE cycle after DONE.
- SHIFT, one iteration per cycle:
  - add 3 to every BCD nibble >= 5;
  - shift {bcd, bin} left by 1.
  - After BIN_W iterations (edges E0+1 .. E0+BIN_W), go to WRITE with digit index 0.
- WRITE: on each of edges E0+BIN_W+1 .. E0+BIN_W+DIGITS, register:
  - write=1;
  - sel=k;
  - num = overflow ? 4'hF : bcd[4k+3:4k], for k = 0..DIGITS-1.
- After digit DIGITS-1, go to DONE. The next edge drives write=0.
- DONE: done=1 for exactly one cycle (edge E0+BIN_W+DIGITS+1), busy=0, then return to IDLE.
- Latency with defaults:
  - first write is visible after edge E0+28;
  - last write after E0+35;
  - done after E0+36;
  - earliest next accepted start is at E0+37.
- Timing is constant regardless of value or overflow; SHIFT always runs BIN_W cycles.
- Overflow digits are all 4'hF. The display decoder shows 'F' on every digit.
- sel does not wrap: the index stops at DIGITS-1. Between operations, sel and num hold their last values with write=0.
- Arithmetic: the nibble correction is 4-bit add, never exceeding 4'hC before shift. Compare 10^DIGITS-1 as a BIN_W-bit constant; elaborate-time assert 10^DIGITS-1 < 2^BIN_W.

Decomposition:
- Shared package display_pkg:
  - state enum typedef (IDLE, SHIFT, WRITE, DONE);
  - localparams DIGITS_DEF=8, BCD_W=4;
  - MAX_DEC constant computed from DIGITS.
- One natural sub-module: bcd_add3_stage. Purely combinational, one nibble: out = in>=5 ? in+3 : in. Instantiated DIGITS times by a generate loop.

Test Plan:
1. reset=0 for 2 cycles, then 1; start=1 with bin_in=12345678 for one cycle -> writes at E0+28..35 with (sel,num) = (0,8)(1,7)(2,6)(3,5)(4,4)(5,3)(6,2)(7,1); done at E0+36; overflow=0.
2. bin_in=0 -> 8 writes, all num=0, sel 0..7.
3. bin_in=99999999 -> all num=9.
4. bin_in=100000000 -> overflow=1 from E0+1; all 8 writes num=4'hF; done at E0+36.
5. While busy (E0+5), a start pulse with bin_in=42 -> ignored; output digits still those of the first value.
6. reset=0 at E0+30 (mid-WRITE) -> write=0, busy=0, state IDLE after that edge; no done pulse. A new start=1 with bin_in=7 -> sel0=7, other digits 0.
